// File: rtl/elastic_rr_arbiter.sv
// Round-robin arbiter feeding one elastic output register stage.
// Optional packet-lock arbitration selected by ELASTIC_RR_ARBITER_LOCK_EN.
module elastic_rr_arbiter #(
   parameter int unsigned WIDTH_P   = 8,
   parameter int unsigned NUM_REQ_P = 4
) (
   input  logic                           clk_i,
   input  logic                           rstn_i,
   input  logic [NUM_REQ_P-1:0]           valid_i,
   input  logic [NUM_REQ_P*WIDTH_P-1:0]   data_i,
`ifdef ELASTIC_RR_ARBITER_LOCK_EN
   input  logic [NUM_REQ_P-1:0]           last_i,
   output logic                           last_o,
`endif
   output logic [NUM_REQ_P-1:0]           ready_o,
   output logic                           valid_o,
   output logic [WIDTH_P-1:0]             data_o,
   output logic [$clog2(NUM_REQ_P)-1:0]   id_o,
   input  logic                           ready_i
);

   localparam int unsigned IdW = $clog2(NUM_REQ_P);

   logic               up_ready;
   logic               found;
   logic               accept;
   logic [IdW-1:0]     grant;
   logic [IdW-1:0]     grant_inc;
   logic [WIDTH_P-1:0] grant_data;
   logic [IdW-1:0]     ptr;
   int unsigned        idx;

`ifdef ELASTIC_RR_ARBITER_LOCK_EN
   logic               locked;
   logic [IdW-1:0]     lock_id;
`endif

   assign up_ready  = ~valid_o | ready_i;
   assign accept    = |(ready_o & valid_i);
   assign grant_inc = (grant == IdW'(NUM_REQ_P - 1)) ? '0 : grant + IdW'(1);

   always_comb begin
      found      = 1'b0;
      grant      = '0;
      grant_data = '0;
      idx        = 0;
      for (int unsigned i = 0; i < NUM_REQ_P; i++) begin
         idx = (32'(ptr) + i) % NUM_REQ_P;
         if (!found && valid_i[idx]) begin
            found      = 1'b1;
            grant      = IdW'(idx);
            grant_data = data_i[idx*WIDTH_P +: WIDTH_P];
         end
      end
`ifdef ELASTIC_RR_ARBITER_LOCK_EN
      // Mid-packet the grant stays on the owner even while its valid is low.
      if (locked) begin
         found      = 1'b1;
         grant      = lock_id;
         grant_data = data_i[32'(lock_id)*WIDTH_P +: WIDTH_P];
      end
`endif
      ready_o = '0;
      if (rstn_i && up_ready && found) ready_o[grant] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         valid_o <= 1'b0;
         data_o  <= '0;
         id_o    <= '0;
         ptr     <= '0;
`ifdef ELASTIC_RR_ARBITER_LOCK_EN
         last_o  <= 1'b0;
         locked  <= 1'b0;
         lock_id <= '0;
`endif
      end else if (up_ready) begin
         valid_o <= accept;
         if (accept) begin
            data_o <= grant_data;
            id_o   <= grant;
`ifdef ELASTIC_RR_ARBITER_LOCK_EN
            last_o <= last_i[grant];
            if (last_i[grant]) begin
               locked <= 1'b0;
               ptr    <= grant_inc;
            end else begin
               locked  <= 1'b1;
               lock_id <= grant;
            end
`else
            ptr    <= grant_inc;
`endif
         end
      end
   end

endmodule
